// File: rtl/operand_decode_stage.sv
// RV32I decode and operand-fetch stage: decodes R/I-type ALU ops, reads a
// 32x32 register file with writeback bypass, and holds the result for the ALU.
module operand_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_AND  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;

  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign funct7   = instr[31:25];

  // Register file: x0 is never written, so it always reads back as zero.
  logic [XLEN-1:0] regs [32];

  // NOTE: the register file is reset as flops because the whole array must
  // read zero immediately after reset; this rules out a RAM macro here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports with write-through bypass from the writeback port.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val = (rs1_addr == 5'd0)                ? '0      :
                   (wb_en && (wb_rd == rs1_addr))    ? wb_data : regs[rs1_addr];
  assign rs2_val = (rs2_addr == 5'd0)                ? '0      :
                   (wb_en && (wb_rd == rs2_addr))    ? wb_data : regs[rs2_addr];

  alu_op_e         dec_op;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_r1;
  logic [XLEN-1:0] dec_r2;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    dec_op      = f3_to_op(funct3);
    dec_illegal = 1'b0;
    dec_r1      = rs1_val;
    dec_r2      = rs2_val;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_ALT && funct3 == 3'b000)      dec_op = OP_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec_op = OP_SRA;
        else if (funct7 != 7'd0)                       dec_illegal = 1'b1;
      end
      OPC_I: begin
        dec_r2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_r2 = {{(XLEN-5){1'b0}}, instr[24:20]};
          if (funct3 == 3'b101 && funct7 == F7_ALT) dec_op = OP_SRA;
          else if (funct7 != 7'd0)                  dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op = OP_ADD;
      dec_r1 = '0;
      dec_r2 = '0;
    end
  end

  logic accept;
  logic capture;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign capture  = accept && !flush;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      alu_op    <= OP_ADD;
      rd        <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // Flush wins over both a new accept and a held output.
      if (flush)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (capture) begin
        r1      <= dec_r1;
        r2      <= dec_r2;
        alu_op  <= dec_op;
        rd      <= rd_addr;
        rd_we   <= !dec_illegal && (rd_addr != 5'd0);
        illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_operand_decode_stage.sv
// Self-checking bench for operand_decode_stage: directed scenarios plus a
// randomized stream compared against an instruction-level reference model.
module tb_operand_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  operand_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .r1(r1), .r2(r2), .alu_op(alu_op), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  // Architectural reference state.
  logic [31:0] m_regs [32];
  exp_t        m_out;

  function automatic logic [31:0] read_m(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  // Instruction-level meaning: SUB/SRA are the "alternate" of ADD/SRL, whose
  // codes are one above the base op selected by funct3.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [3:0] base [8];
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt, legal, shift;
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = ins[14:12];
    f7 = ins[31:25];
    alt = (f7 == 7'h20);
    shift = (f3 == 3'd1 || f3 == 3'd5);
    e = '0;
    e.valid = 1'b1;
    e.rd = ins[11:7];
    legal = 1'b0;
    if (ins[6:0] == 7'h33) begin
      legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      e.op = base[f3] + {3'd0, alt};
      e.r1 = a;
      e.r2 = b;
    end else if (ins[6:0] == 7'h13) begin
      e.r1 = a;
      if (shift) begin
        legal = (f7 == 7'h00) || (alt && f3 == 3'd5);
        e.op = base[f3] + {3'd0, alt};
        e.r2 = {27'd0, ins[24:20]};
      end else begin
        legal = 1'b1;
        e.op = base[f3];
        e.r2 = 32'($signed(ins[31:20]));
      end
    end
    if (!legal) begin
      e.op = 4'd0;
      e.r1 = 32'd0;
      e.r2 = 32'd0;
    end
    e.illegal = !legal;
    e.rd_we = legal && (ins[11:7] != 5'd0);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_out = '0;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; instr = 32'd0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
  endtask

  // One clock: inputs are already applied at edge+1; compare in_ready before
  // the edge and all outputs 1 time unit after it.
  task automatic cycle();
    exp_t nxt;
    logic exp_rdy;
    #1;
    exp_rdy = !m_out.valid || out_ready;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_rdy);
    end
    nxt = m_out;
    if (flush) nxt.valid = 1'b0;
    else if (in_valid && exp_rdy) nxt = ref_decode(instr, read_m(instr[19:15]), read_m(instr[24:20]));
    else if (out_ready) nxt.valid = 1'b0;
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    @(posedge clk); #1;
    m_out = nxt;
    checks++;
    if (out_valid !== m_out.valid) begin
      errors++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, m_out.valid);
    end else if (m_out.valid) begin
      checks++;
      if ({r1, r2, alu_op, rd, rd_we, illegal} !== {m_out.r1, m_out.r2, m_out.op, m_out.rd, m_out.rd_we, m_out.illegal}) begin
        errors++;
        $display("FAIL outputs @%0t: got r1=%h r2=%h op=%h rd=%0d we=%b ill=%b expected r1=%h r2=%h op=%h rd=%0d we=%b ill=%b",
                 $time, r1, r2, alu_op, rd, rd_we, illegal,
                 m_out.r1, m_out.r2, m_out.op, m_out.rd, m_out.rd_we, m_out.illegal);
      end
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, r1, r2, alu_op, rd, rd_we, illegal, in_ready} !== {1'b0, 64'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b r1=%h r2=%h op=%h rd=%0d we=%b ill=%b rdy=%b expected all zero with ready=1",
               out_valid, r1, r2, alu_op, rd, rd_we, illegal, in_ready);
    end
  endtask

  task automatic test_basic();
    set_idle();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; cycle();
    wb_rd = 5'd2; wb_data = 32'd7; cycle();
    set_idle();
    in_valid = 1'b1; instr = 32'h002081B3; cycle();
    checks++;
    if ({out_valid, r1, r2, alu_op, rd, rd_we} !== {1'b1, 32'd5, 32'd7, 4'd0, 5'd3, 1'b1}) begin
      errors++;
      $display("FAIL add_basic: got v=%b r1=%h r2=%h op=%h rd=%0d we=%b expected 1 5 7 0 3 1",
               out_valid, r1, r2, alu_op, rd, rd_we);
    end
    instr = 32'hFFF08213; cycle();
    checks++;
    if ({r2, alu_op} !== {32'hFFFFFFFF, 4'd0}) begin
      errors++;
      $display("FAIL addi_neg: got r2=%h op=%h expected ffffffff 0", r2, alu_op);
    end
    instr = 32'h4030D293; cycle();
    checks++;
    if ({r2, alu_op} !== {32'd3, 4'd7}) begin
      errors++;
      $display("FAIL srai: got r2=%h op=%h expected 3 7", r2, alu_op);
    end
    set_idle(); cycle();
  endtask

  task automatic test_bypass();
    set_idle();
    in_valid = 1'b1; instr = 32'h40108333;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF; cycle();
    checks++;
    if ({r1, r2, alu_op} !== {32'hDEADBEEF, 32'hDEADBEEF, 4'd1}) begin
      errors++;
      $display("FAIL bypass_sub: got r1=%h r2=%h op=%h expected deadbeef deadbeef 1", r1, r2, alu_op);
    end
    // Write x0 in the same cycle as a read of x0, then read it again later.
    wb_rd = 5'd0; wb_data = 32'd9; instr = 32'h00000393; cycle();
    checks++;
    if (r1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_bypass: got r1=%h expected 0", r1);
    end
    wb_en = 1'b0; instr = 32'h00000433; cycle();
    checks++;
    if ({r1, r2, rd_we} !== {64'd0, 1'b1}) begin
      errors++;
      $display("FAIL x0_read: got r1=%h r2=%h we=%b expected 0 0 1", r1, r2, rd_we);
    end
    set_idle(); cycle();
  endtask

  task automatic test_stall();
    set_idle();
    in_valid = 1'b1; instr = 32'h002081B3; cycle();
    out_ready = 1'b0; instr = 32'h00108093;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h00001234;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({in_ready, out_valid, r1} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b r1=%h expected 0 1 deadbeef", i, in_ready, out_valid, r1);
      end
    end
    set_idle(); cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got out_valid=%b expected 0", out_valid);
    end
    in_valid = 1'b1; instr = 32'h00008513; cycle();
    checks++;
    if (r1 !== 32'h00001234) begin
      errors++;
      $display("FAIL stall_write: got r1=%h expected 00001234", r1);
    end
    set_idle(); cycle();
  endtask

  task automatic test_illegal_flush();
    set_idle();
    in_valid = 1'b1; instr = 32'h0000007F; cycle();
    checks++;
    if ({illegal, rd_we, alu_op, r1, r2} !== {1'b1, 1'b0, 4'd0, 64'd0}) begin
      errors++;
      $display("FAIL illegal: got ill=%b we=%b op=%h r1=%h r2=%h expected 1 0 0 0 0", illegal, rd_we, alu_op, r1, r2);
    end
    flush = 1'b1; instr = 32'h002081B3; cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: got out_valid=%b expected 0", out_valid);
    end
    set_idle(); cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k, p;
    w = $urandom;
    k = $urandom_range(0, 9);
    p = $urandom_range(0, 9);
    f7 = (p < 6) ? 7'h00 : (p < 9) ? 7'h20 : 7'($urandom);
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    if (k < 4) begin
      w[6:0] = 7'h33; w[31:25] = f7;
    end else if (k < 8) begin
      w[6:0] = 7'h13;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = f7;
    end else if (k == 9) begin
      w[6:0] = 7'h7F;
    end
    return w;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      cycle();
    end
    set_idle(); cycle();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    in_valid = 1'b1; instr = 32'h002081B3; cycle();
    in_valid = 1'b0; out_ready = 1'b0; cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    set_idle();
    in_valid = 1'b1; instr = 32'h002081B3; cycle();
    checks++;
    if ({out_valid, r1, r2} !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL regs_after_reset: got v=%b r1=%h r2=%h expected 1 0 0", out_valid, r1, r2);
    end
    set_idle(); cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_illegal_flush();
    test_random();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
